// File: rtl/rc_pkg.sv
// Shared constants and FSM encoding for the nibble-serial ripple-carry adder.
package rc_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned SLICE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rc_add_seq_if.sv
// Request/response bundle for rc_add_seq: valid/ready request in, valid/ready result out.
interface rc_add_seq_if
    import rc_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             carry;

    // Requester / result consumer side.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, s, carry
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, s, carry
    );

endinterface

// File: rtl/rc_adder.sv
// Combinational W-bit ripple-carry adder slice.
module rc_adder #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] c;

    // Ripple the carry bit by bit from cin to cout.
    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[W];
    end

endmodule

// File: rtl/rc_add_seq.sv
// Sequences one shared SLICE-bit rc_adder over WIDTH/SLICE passes to form a
// WIDTH-bit sum, chaining the slice carry through carry_reg between passes.
module rc_add_seq
    import rc_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SLICE = SLICE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    rc_add_seq_if.slave  bus
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             carry_reg;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_s;
    logic             slice_c;

    assign slice_a = a_reg[cnt*SLICE +: SLICE];
    assign slice_b = b_reg[cnt*SLICE +: SLICE];

    rc_adder #(
        .W(SLICE)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_c)
    );

    assign bus.s     = s_reg;
    assign bus.carry = carry_reg;

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus operand capture and per-pass slice write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        carry_reg <= bus.cin;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    s_reg[cnt*SLICE +: SLICE] <= slice_s;
                    carry_reg                 <= slice_c;
                    // Counter parks on the last pass instead of wrapping.
                    if (cnt != LAST) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc_add_seq.sv
// Scoreboard bench for rc_add_seq: the driver pushes a+b+cin per accepted
// request, and a negedge monitor checks every presented result in order.
module tb_rc_add_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [16:0] q[$];

    rc_add_seq_if #(.WIDTH(16)) bus ();

    rc_add_seq #(
        .WIDTH(16),
        .SLICE(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares presented results against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("out_valid_without_request", 32'(bus.out_valid), 32'd0);
            end else begin
                chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
                if (bus.out_ready) begin
                    chk("sum", 32'(bus.s), 32'(q[0][15:0]));
                    chk("carry", 32'(bus.carry), 32'(q[0][16]));
                    void'(q.pop_front());
                end else begin
                    chk("hold_sum", 32'(bus.s), 32'(q[0][15:0]));
                    chk("hold_carry", 32'(bus.carry), 32'(q[0][16]));
                end
            end
        end
    end

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        output int acc);
        int n;
        n = 0;
        acc = -1;
        bus.a = av;
        bus.b = bv;
        bus.cin = cv;
        bus.in_valid = 1'b1;
        while (n < 100) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
        end
        if (n >= 100) begin
            chk("accept_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            q.push_back({1'b0, av} + {1'b0, bv} + 17'(cv));
            @(posedge clk);
            #1;
            acc = cyc;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, n, c0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_s", 32'(bus.s), 32'd0);
        chk("rst_carry", 32'(bus.carry), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic add, latency and return to IDLE.
        send(16'd134, 16'd34, 1'b1, t0);
        wait_valid(n);
        chk("latency", 32'(n), 32'd4);
        @(posedge clk);
        #1;
        chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
        chk("out_valid_after_hs", 32'(bus.out_valid), 32'd0);

        // Full carry ripple, then all-ones and zero with no carry leaking.
        send(16'hFFFF, 16'h0001, 1'b0, t0);
        send(16'hFFFF, 16'hFFFF, 1'b1, t0);
        send(16'h0000, 16'h0000, 1'b0, t0);
        drain();

        // Backpressure: result held for 10 cycles while in_valid is ignored.
        bus.out_ready = 1'b0;
        send(16'h1234, 16'h4321, 1'b0, t0);
        wait_valid(n);
        repeat (10) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
        end
        chk("q_depth_under_backpressure", 32'(q.size()), 32'd1);
        // Consume and request in the same DONE cycle: accept slips one cycle.
        c0 = cyc;
        bus.out_ready = 1'b1;
        send(16'd5, 16'd6, 1'b1, t1);
        chk("accept_after_consume", 32'(t1 - c0), 32'd2);
        drain();

        // Reset in the 2nd RUN cycle aborts the request.
        send(16'hABCD, 16'h1111, 1'b1, t0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrun_rst_s", 32'(bus.s), 32'd0);
        chk("midrun_rst_carry", 32'(bus.carry), 32'd0);
        chk("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
        void'(q.pop_back());
        @(posedge clk);
        #3;
        rst = 1'b0;
        send(16'd10, 16'd20, 1'b0, t0);
        drain();

        // Back-to-back accepts with in_valid held.
        send(16'd134, 16'd34, 1'b1, t0);
        send(16'hFFFF, 16'h0001, 1'b0, t1);
        send(16'd10, 16'd20, 1'b0, t2);
        chk("spacing_1", 32'(t1 - t0), 32'd6);
        chk("spacing_2", 32'(t2 - t1), 32'd6);
        drain();

        // Randomized requests with random idle gaps.
        for (int i = 0; i < 20; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), t0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
